// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles every bus signal around the data-memory arbiter: the CPU MEM-stage
//   port, the peripheral req/ack port and the single data-memory port.
//   clk/reset stay outside the interface.
//
//   Handshake rules:
//     CPU side   : cpu_req is a same-cycle request; the access completes in the
//                  cycle cpu_req=1 and cpu_stall=0, otherwise the MEM stage
//                  holds its request and fields unchanged.
//     Peripheral : per_req with per_we/per_addr/per_wdata is held stable until
//                  the cycle per_ack=1 (one-cycle pulse, per_err/per_rdata valid
//                  with it); in that cycle the requester drops or changes its
//                  request.
//     Memory     : MemRead/MemWrite/Address/Write_data are combinational;
//                  Read_data returns combinationally in the same cycle.
//
//   Modports:
//     slave  : the arbiter itself
//     master : the environment (MEM stage, peripheral and data memory)
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        per_req;
  logic        per_we;
  logic [31:0] per_addr;
  logic [31:0] per_wdata;
  logic [31:0] per_rdata;
  logic        per_ack;
  logic        per_err;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  per_req, per_we, per_addr, per_wdata,
    output per_rdata, per_ack, per_err,
    output MemRead, MemWrite, Address, Write_data,
    input  Read_data
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output per_req, per_we, per_addr, per_wdata,
    input  per_rdata, per_ack, per_err,
    input  MemRead, MemWrite, Address, Write_data,
    output Read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data-memory port between the CPU MEM stage (fixed
//   priority, zero added latency) and a peripheral master (req/ack). A
//   starvation counter forces one peripheral slot after STARVE_LIMIT
//   consecutive denied cycles. Peripheral accesses at or above RAM_BYTES are
//   rejected with per_err and never reach the memory.
//
//   Ports:
//     clk, reset      : clock, synchronous active-high reset
//     bus (slave)     : CPU, peripheral and data-memory signals
//     dbg_state       : FSM state (0 = IDLE, 1 = ACK)
//     dbg_starve_cnt  : current starvation count
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int RAM_BYTES    = 2048
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus,
  output logic          dbg_state,
  output logic [3:0]    dbg_starve_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_e;

  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [31:0] RAM_LIMIT  = 32'(RAM_BYTES);

  state_e      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        per_ack_q, per_ack_d;
  logic        per_err_q, per_err_d;
  logic [31:0] per_rdata_q, per_rdata_d;

  logic        in_range;
  logic        gnt_per;
  logic        gnt_cpu;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] cpu_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      starve_cnt_q <= 4'd0;
      per_ack_q    <= 1'b0;
      per_err_q    <= 1'b0;
      per_rdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      per_ack_q    <= per_ack_d;
      per_err_q    <= per_err_d;
      per_rdata_q  <= per_rdata_d;
    end
  end

  always_comb begin
    in_range = bus.per_addr < RAM_LIMIT;
    // The ACK cycle makes the peripheral ineligible, so a request still held
    // while its ack is visible can never be granted twice.
    gnt_per  = (state_q == S_IDLE) && bus.per_req &&
               (!bus.cpu_req || (starve_cnt_q == STARVE_MAX));
    gnt_cpu  = bus.cpu_req && !gnt_per;

    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (gnt_cpu) begin
      mem_read  = !bus.cpu_we;
      mem_write = bus.cpu_we;
      mem_addr  = bus.cpu_addr;
      mem_wdata = bus.cpu_wdata;
    end else if (gnt_per && in_range) begin
      mem_read  = !bus.per_we;
      mem_write = bus.per_we;
      mem_addr  = bus.per_addr;
      mem_wdata = bus.per_wdata;
    end

    cpu_rdata = gnt_cpu ? bus.Read_data : 32'd0;

    // ACK always falls back to IDLE; IDLE moves to ACK only on a grant.
    state_d     = gnt_per ? S_ACK : S_IDLE;
    per_ack_d   = gnt_per;
    per_err_d   = gnt_per && !in_range;
    per_rdata_d = (gnt_per && in_range && !bus.per_we) ? bus.Read_data : 32'd0;

    starve_cnt_d = starve_cnt_q;
    if (gnt_per) begin
      starve_cnt_d = 4'd0;
    end else if ((state_q == S_IDLE) && bus.per_req && bus.cpu_req &&
                 (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  assign bus.MemRead    = mem_read;
  assign bus.MemWrite   = mem_write;
  assign bus.Address    = mem_addr;
  assign bus.Write_data = mem_wdata;
  assign bus.cpu_rdata  = cpu_rdata;
  assign bus.cpu_stall  = bus.cpu_req && gnt_per;
  assign bus.per_ack    = per_ack_q;
  assign bus.per_err    = per_err_q;
  assign bus.per_rdata  = per_rdata_q;

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_cnt_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter in front of the pipeline's data memory. It shares the single data-memory port between the CPU MEM stage and a peripheral master (UART loader or DMA), which uses a req/ack handshake. The CPU has fixed priority, and a starvation counter forces the peripheral one slot when it has waited too long. The block sits between the MEM stage and the DataMemory instance and drives that instance's MemRead/MemWrite/Address/Write_data.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive denied peripheral cycles before a forced peripheral grant (1..15).
- RAM_BYTES, 2048: byte size of the RAM window; peripheral addresses at or above this are rejected.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  CPU MEM stage has a load or store this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU store data.
- cpu_rdata  out  32  load data; Read_data when the CPU is granted, else 0.
- cpu_stall  out  1  CPU request not served this cycle; the pipeline must hold the MEM stage.
- per_req  in  1  peripheral request; held stable with its we/addr/wdata until per_ack.
- per_we  in  1  peripheral write enable.
- per_addr  in  32  peripheral byte address.
- per_wdata  in  32  peripheral write data.
- per_rdata  out  32  registered read data, valid while per_ack=1.
- per_ack  out  1  one-cycle completion pulse.
- per_err  out  1  valid with per_ack; the access was rejected because it fell outside the RAM window.
- MemRead  out  1  to data memory.
- MemWrite  out  1  to data memory.
- Address  out  32  to data memory.
- Write_data  out  32  to data memory.
- Read_data  in  32  combinational read data from data memory.

## Operation
- States: IDLE (accept arbitration) and ACK (per_ack cycle; the peripheral is not eligible).
- Grant is combinational each cycle from requests, state and starve_cnt:
  - gnt_per = state==IDLE & per_req & (!cpu_req | starve_cnt==STARVE_LIMIT).
  - gnt_cpu = cpu_req & !gnt_per.
- cpu_stall = cpu_req & gnt_per.
- Memory mux:
  - gnt_cpu: drive the CPU fields; MemRead=!cpu_we, MemWrite=cpu_we.
  - gnt_per with in-range address: drive the peripheral fields likewise.
  - Otherwise (including an out-of-range peripheral grant): MemRead=MemWrite=0, Address=0, Write_data=0.
- Peripheral in range means per_addr < RAM_BYTES. The CPU path is never range-checked; MMIO such as 0x40000010 passes through.
- On gnt_per the block registers:
  - per_rdata = in-range read ? Read_data : 0.
  - per_err = !in-range.
  - per_ack = 1, and state moves to ACK.
- ACK returns to IDLE unconditionally after one cycle. per_ack, per_err and per_rdata clear in that cycle unless a new grant occurs; a new grant cannot occur in ACK.
- starve_cnt (4 bits):
  - Increments when state==IDLE & per_req & cpu_req & !gnt_per, saturating at STARVE_LIMIT.
  - Clears on gnt_per.
  - Holds otherwise.
- Simultaneous CPU and peripheral requests: the CPU wins unless starve_cnt==STARVE_LIMIT.

## Timing
- CPU access has zero added latency; data is combinational through cpu_rdata in the grant cycle.
- Peripheral access: per_ack is high in the cycle after the grant. Minimum request-to-ack time is 1 cycle; the maximum is STARVE_LIMIT+1 cycles under continuous CPU traffic.
- Peripheral throughput is at most one access per 2 cycles, because of the ACK cycle.
- The requester must drop or change per_req in the same cycle it samples per_ack=1. ACK-state blocking prevents a duplicate grant.
- Reset values: per_ack=0, per_err=0, per_rdata=0, state=IDLE, starve_cnt=0.
- Reset takes priority over everything. A request pending at reset gets no ack; the requester must re-issue it.
- The memory-side outputs are combinational. The data-memory write happens on the same posedge that registers per_ack.

## Test plan
- **Idle peripheral read:** reset, then RAM[200]=0x3F via the CPU. Peripheral reads 0x320 with cpu_req=0. Expect per_ack=1 the next cycle, per_rdata=0x3F, per_err=0, cpu_stall never asserted.
- **Starvation:** cpu_req held high; per_req for address 0x10 asserted at cycle 0. Expect cpu_stall=0 for cycles 0-3, gnt_per and cpu_stall=1 at cycle 4, per_ack at cycle 5, starve_cnt=0 afterwards.
- **Out-of-range write:** peripheral write to 0x800 with data 0xDEAD. Expect MemWrite=0 throughout, per_ack=1 with per_err=1 and per_rdata=0, and no RAM change.
- **Back-to-back requests:** per_req kept high across the ack cycle with no CPU traffic. Expect grants on cycles 0, 2, 4, per_ack on cycles 1, 3, 5, and never two consecutive acks.
- **Reset mid-request:** per_req high with cpu_req high and starve_cnt=2; assert reset for one cycle. Expect per_ack=0 and starve_cnt=0 after reset, and a fresh count to 4 before the forced grant.
- **CPU MMIO store:** CPU store to 0x40000010 of 0xABC. Expect Address=0x40000010, MemWrite=1, no stall, and no per_err.
